// File: rtl/cpu_io_port.sv
// rtl/cpu_io_port.sv - host-side operand register and change-capture FIFO around the pipelined CPU
//
// cpu_io_port ports:
//   clk            : clock, all state on rising edge
//   reset          : asynchronous active-low reset
//   cpu_in         : operand driven into the CPU in port (host loadable)
//   cpu_out        : CPU out port, watched for cycle-to-cycle changes
//   host_in_data   : new cpu_in value
//   host_in_load   : load strobe for host_in_data
//   host_out_data  : FIFO head (0 when empty)
//   host_out_valid : FIFO non-empty
//   host_out_ready : host accepts the head entry
//   clear          : synchronous flush of FIFO, overflow and change history
//   count          : FIFO occupancy
//   overflow       : sticky, a captured change was dropped
//
// cpu_io_fifo ports:
//   s_tdata/s_tvalid          : push side (no backpressure, drops when full)
//   m_tdata/m_tvalid/m_tready : first-word-fall-through pop side
//   count/overflow            : occupancy and sticky drop flag

module cpu_io_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [DW-1:0]            s_tdata,
    input  logic                     s_tvalid,
    output logic [DW-1:0]            m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = !empty && m_tready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_push  = s_tvalid && (!full || do_pop);
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_tvalid && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (reset && !clear && do_push) begin
            mem[wptr] <= s_tdata;
        end
    end
endmodule

module cpu_io_port #(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] IN_INIT = 16'd3
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [15:0]            cpu_in,
    input  logic [15:0]            cpu_out,
    input  logic [15:0]            host_in_data,
    input  logic                   host_in_load,
    output logic [15:0]            host_out_data,
    output logic                   host_out_valid,
    input  logic                   host_out_ready,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    logic [15:0] prev;
    logic        chg;
    logic        push;

    assign chg  = (cpu_out != prev);
    // Clear resynchronises prev to cpu_out, so the flush edge never captures.
    assign push = chg && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_in <= IN_INIT;
            prev   <= '0;
        end else begin
            if (host_in_load) begin
                cpu_in <= host_in_data;
            end
            // prev tracks cpu_out even when the push is dropped on a full FIFO.
            if (clear || chg) begin
                prev <= cpu_out;
            end
        end
    end

    cpu_io_fifo #(
        .DEPTH (DEPTH),
        .DW    (16)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .s_tdata  (cpu_out),
        .s_tvalid (push),
        .m_tdata  (host_out_data),
        .m_tvalid (host_out_valid),
        .m_tready (host_out_ready),
        .count    (count),
        .overflow (overflow)
    );
endmodule

// File: tb/tb_cpu_io_port.sv
// tb/tb_cpu_io_port.sv - scoreboard bench for cpu_io_port

module tb_cpu_io_port;
    logic        clk;
    logic        reset;
    logic [15:0] cpu_in;
    logic [15:0] cpu_out;
    logic [15:0] host_in_data;
    logic        host_in_load;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic        clear;
    logic [3:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb [$];

    cpu_io_port #(
        .DEPTH   (8),
        .IN_INIT (16'd3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_in         (cpu_in),
        .cpu_out        (cpu_out),
        .host_in_data   (host_in_data),
        .host_in_load   (host_in_load),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .clear          (clear),
        .count          (count),
        .overflow       (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new cpu_out value for the next edge and optionally expect it in the FIFO.
    task automatic drive(input logic [15:0] v, input bit expect_push);
        cpu_out = v;
        if (expect_push) sb.push_back(v);
        tick();
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        host_out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (count == 4'd0) begin
                done = 1'b1;
                break;
            end
        end
        host_out_ready = 1'b0;
        chk({name, "_drained"}, {31'd0, done}, 32'd1);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    // Monitor: every accepted head is compared against the scoreboard front.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (reset && host_out_valid && host_out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got 0x%0h expected no entry", host_out_data);
                end else begin
                    exp = sb.pop_front();
                    chk("pop_data", host_out_data, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        cpu_out        = 16'h0000;
        host_in_data   = 16'h0000;
        host_in_load   = 1'b0;
        host_out_ready = 1'b0;
        clear          = 1'b0;

        // Reset defaults
        tick();
        tick();
        chk("rst_cpu_in", cpu_in, 32'h3);
        chk("rst_valid", host_out_valid, 32'h0);
        chk("rst_count", count, 32'h0);
        chk("rst_overflow", overflow, 32'h0);
        chk("rst_data", host_out_data, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_count", count, 32'h0);
        chk("idle_valid", host_out_valid, 32'h0);

        // Input load
        host_in_data = 16'hBEEF;
        host_in_load = 1'b1;
        tick();
        host_in_load = 1'b0;
        host_in_data = 16'h0000;
        chk("load_cpu_in", cpu_in, 32'hBEEF);

        // Capture sequence with one-cycle latency
        cpu_out = 16'h0005;
        sb.push_back(16'h0005);
        chk("cap_valid_before", host_out_valid, 32'h0);
        tick();
        chk("cap_valid_after", host_out_valid, 32'h1);
        drive(16'h0005, 1'b0);
        chk("cap_repeat_count", count, 32'h1);
        drive(16'h0007, 1'b1);
        drive(16'h0000, 1'b1);
        chk("cap_count", count, 32'h3);
        chk("cap_head", host_out_data, 32'h5);
        drain("cap");

        // Full and overflow: 9 values, the ninth dropped
        for (int v = 1; v <= 9; v++) drive(16'(v), v <= 8);
        chk("ovf_count", count, 32'h8);
        chk("ovf_flag", overflow, 32'h1);
        drive(16'd9, 1'b0);
        chk("ovf_repeat_count", count, 32'h8);
        drain("ovf");
        chk("ovf_sticky", overflow, 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovf_clear_flag", overflow, 32'h0);
        chk("ovf_clear_count", count, 32'h0);

        // Full with simultaneous pop
        for (int v = 16'h11; v <= 16'h18; v++) drive(16'(v), 1'b1);
        chk("fp_count_full", count, 32'h8);
        host_out_ready = 1'b1;
        drive(16'h00AA, 1'b1);
        host_out_ready = 1'b0;
        chk("fp_count", count, 32'h8);
        chk("fp_overflow", overflow, 32'h0);
        chk("fp_head", host_out_data, 32'h12);
        drain("fp");

        // Clear with count=5 and overflow set, cpu_out changing on the clear edge
        for (int v = 16'h21; v <= 16'h29; v++) drive(16'(v), v <= 16'h28);
        host_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        host_out_ready = 1'b0;
        chk("clr_pre_count", count, 32'h5);
        chk("clr_pre_ovf", overflow, 32'h1);
        clear   = 1'b1;
        cpu_out = 16'h1234;
        tick();
        clear = 1'b0;
        sb.delete();
        chk("clr_count", count, 32'h0);
        chk("clr_ovf", overflow, 32'h0);
        chk("clr_valid", host_out_valid, 32'h0);
        chk("clr_cpu_in", cpu_in, 32'hBEEF);
        host_out_ready = 1'b1;
        tick();
        tick();
        host_out_ready = 1'b0;
        chk("clr_no_push", count, 32'h0);

        // Async reset mid-operation
        for (int v = 16'h31; v <= 16'h34; v++) drive(16'(v), 1'b1);
        chk("ar_pre_count", count, 32'h4);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("ar_cpu_in", cpu_in, 32'h3);
        chk("ar_count", count, 32'h0);
        chk("ar_valid", host_out_valid, 32'h0);
        chk("ar_data", host_out_data, 32'h0);
        @(posedge clk);
        #1;
        // Release with cpu_out=0x0034 != prev=0: the first edge captures it.
        reset = 1'b1;
        sb.push_back(16'h0034);
        tick();
        chk("rel_count", count, 32'h1);
        chk("rel_head", host_out_data, 32'h34);
        drain("rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_io_port.md
# cpu_io_port

Host-side I/O port for the 16-bit pipelined CPU. It drives the CPU's 16-bit `in` operand bus from a host-loadable register and watches the CPU's 16-bit `out` bus. Every cycle-to-cycle change on `out` is captured into a first-word-fall-through FIFO, which the host drains with a valid/ready handshake. It sits directly around the CPU top: its `cpu_in` feeds the CPU `in` port, and its `cpu_out` consumes the CPU `out` port.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `IN_INIT`, 16'd3: reset value of `cpu_in`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `cpu_in`, output, 16: operand value driven into the CPU `in` port.
- `cpu_out`, input, 16: CPU `out` port value.
- `host_in_data`, input, 16: new value for `cpu_in`.
- `host_in_load`, input, 1: load strobe for `host_in_data`.
- `host_out_data`, output, 16: FIFO head value.
- `host_out_valid`, output, 1: FIFO non-empty.
- `host_out_ready`, input, 1: host accepts the head entry.
- `clear`, input, 1: synchronous flush.
- `count`, output, log2(DEPTH)+1: current FIFO occupancy.
- `overflow`, output, 1: sticky flag; set when a captured change was dropped.

## Operation
- **Input register:** `cpu_in` <= `host_in_data` on any edge with `host_in_load`=1; otherwise it holds.
- **Change detector:**
  - Register `prev` resets to 0.
  - Per edge, `chg` = (`cpu_out` != `prev`).
  - When `chg`=1, `prev` <= `cpu_out`, regardless of whether the push is accepted.
- **FIFO storage:** circular buffer with write pointer, read pointer and `count`; pointers wrap modulo DEPTH.
- **Push:** requested when `chg`=1; the written value is `cpu_out` sampled at that edge.
- **Pop:** occurs when `host_out_valid` && `host_out_ready`.
- **Per-edge resolution, with `clear`=0:**
  - push only, not full: write entry, `count`+1.
  - pop only: advance read pointer, `count`-1.
  - push and pop, not full and not empty: both happen, `count` unchanged.
  - push while full, with pop: both happen, `count` stays DEPTH, no overflow.
  - push while full, no pop: value dropped, `overflow` <= 1, `prev` still updated.
  - push while empty: no bypass; the entry becomes visible the next cycle.
- **Clear** has priority over push and pop:
  - `count` <= 0 and both pointers <= 0.
  - `overflow` <= 0.
  - `prev` <= `cpu_out`, so nothing is pushed that cycle.
  - `cpu_in` is unaffected by `clear`.
- **Outputs:**
  - `host_out_valid` = (`count` != 0).
  - `host_out_data` = storage at the read pointer when valid; 16'h0000 when empty.
- **Overflow flag:** cleared only by `reset` or `clear`.

## Timing
- **Reset values (asynchronous):**
  - `cpu_in`=IN_INIT.
  - `count`=0, `host_out_valid`=0, `host_out_data`=0, `overflow`=0.
  - pointers=0, `prev`=0.
- **Reset release:** the first rising edge after `reset` goes high is a normal edge. If `cpu_out`≠0 at that edge, it is pushed.
- **Reset mid-operation:** asserting `reset` empties the FIFO immediately; queued data is lost.
- **Capture latency:** `cpu_out` changes before edge k; the value is written at edge k, and `host_out_valid` rises after edge k (FIFO was empty). That is 1 cycle.
- **Change resolution:** changes narrower than one clock period between edges are invisible; one push at most per cycle.
- **Load latency:** `host_in_load` sampled at edge k; `cpu_in` takes the new value after edge k.
- **Pop timing:** the pop takes effect at the edge where valid && ready; the next head appears after that edge.
- **Handshake rules:**
  - `host_out_data` is stable while valid=1 and no pop occurs.
  - `host_out_ready` may be held high permanently.
  - valid does not depend combinationally on ready.

## Test plan
- **Reset defaults:** hold `reset`=0 for 2 cycles, `cpu_out`=0 -> `cpu_in`=3, valid=0, `count`=0, `overflow`=0, `host_out_data`=0; after release with `cpu_out` constant 0, no push for 10 cycles.
- **Capture sequence:** drive `cpu_out` 0x0005, 0x0005, 0x0007, 0x0000 on consecutive cycles, ready=0 -> `count`=3 with entries 0x0005, 0x0007, 0x0000 in order; valid rises 1 cycle after 0x0005 is sampled.
- **Full and overflow:** DEPTH=8, ready=0, 9 distinct consecutive values 1..9 -> `count`=8, `overflow`=1, drained data 1..8; a 10th value equal to 9 produces no push, because `prev` was updated to 9.
- **Full with simultaneous pop:** `count`=8, ready=1, new value 0x00AA -> head pops, 0x00AA accepted, `count`=8, `overflow`=0.
- **Clear:** `count`=5, `overflow`=1, `clear`=1 for one cycle with `cpu_out` changing to 0x1234 that same cycle -> `count`=0, `overflow`=0, no push of 0x1234; next cycle with `cpu_out` still 0x1234 -> no push.
- **Input load and async reset:** `host_in_load`=1, `host_in_data`=0xBEEF -> `cpu_in`=0xBEEF after that edge. Then assert `reset` mid-cycle with `count`=4 -> `cpu_in`=3 and `count`=0 immediately, without waiting for a clock edge.
